// File: rtl/axis_tone_gen.sv
// AXI4-Stream test-tone master: sine, square, ramp and impulse waveforms with per-point hold,
// attenuation and full tready backpressure. Registered outputs; tlast marks the end of each period.
module axis_tone_gen #(
  parameter int DATA_W   = 16,
  parameter int PTS_LOG2 = 3,
  parameter int HOLD_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [HOLD_W-1:0]     hold_cycles,
  input  logic [3:0]            attn,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [15:0]           period_cnt
);

  localparam logic [PTS_LOG2-1:0] LAST_PH = '1;
  localparam logic [DATA_W-1:0]   S_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]   S_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_nx;
  logic [PTS_LOG2-1:0]   phase, phase_nx;
  logic [HOLD_W-1:0]     hold, hold_nx;
  logic [1:0]            mode_l, mode_nx;
  logic [HOLD_W-1:0]     hold_l, hold_l_nx;
  logic [3:0]            attn_l, attn_nx;
  logic [15:0]           pc_nx;
  logic                  tvalid_nx, tlast_nx, load, accept;
  logic [DATA_W-1:0]     tdata_nx;
  logic [DATA_W/8-1:0]   tkeep_nx;

  function automatic logic [DATA_W-1:0] gen_sample(input logic [1:0] m, input logic [3:0] a,
                                                   input logic [PTS_LOG2-1:0] p);
    logic [31:0]              w;
    logic [15:0]              s16;
    logic signed [DATA_W-1:0] raw;
    w   = '0;
    s16 = '0;
    raw = '0;
    case (m)
      2'd0: begin
        case (p[PTS_LOG2-1 -: 3])
          3'd0:    s16 = 16'h0000;
          3'd1:    s16 = 16'h5A7E;
          3'd2:    s16 = 16'h7FFF;
          3'd3:    s16 = 16'h5A7E;
          3'd4:    s16 = 16'h0000;
          3'd5:    s16 = 16'hA582;
          3'd6:    s16 = 16'h8000;
          default: s16 = 16'hA582;
        endcase
        // Left-justify in 32 bits so one slice covers both wider and narrower samples.
        w   = {s16, 16'h0000};
        raw = w[31 -: DATA_W];
      end
      2'd1: raw = p[PTS_LOG2-1] ? S_MIN : S_MAX;
      2'd2: begin
        w     = 32'(p) << (32 - PTS_LOG2);
        w[31] = ~w[31];
        raw   = w[31 -: DATA_W];
      end
      default: raw = (p == '0) ? S_MAX : '0;
    endcase
    return raw >>> a;
  endfunction

  assign accept = m_axis_tvalid & m_axis_tready;

  always_comb begin
    state_nx  = state;
    phase_nx  = phase;
    hold_nx   = hold;
    mode_nx   = mode_l;
    hold_l_nx = hold_l;
    attn_nx   = attn_l;
    pc_nx     = period_cnt;
    tvalid_nx = m_axis_tvalid;
    tdata_nx  = m_axis_tdata;
    tkeep_nx  = m_axis_tkeep;
    tlast_nx  = m_axis_tlast;
    load      = 1'b0;

    case (state)
      IDLE: begin
        if (enable) begin
          state_nx  = RUN;
          mode_nx   = mode;
          hold_l_nx = hold_cycles;
          attn_nx   = attn;
          phase_nx  = '0;
          hold_nx   = '0;
          pc_nx     = '0;
          load      = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (accept) begin
          if (m_axis_tlast) pc_nx = period_cnt + 16'd1;
          if (state == DRAIN || !enable) begin
            state_nx  = IDLE;
            phase_nx  = '0;
            hold_nx   = '0;
            tvalid_nx = 1'b0;
            tdata_nx  = '0;
            tkeep_nx  = '0;
            tlast_nx  = 1'b0;
          end else begin
            load = 1'b1;
            if (hold == hold_l) begin
              hold_nx  = '0;
              phase_nx = phase + 1'b1;
            end else begin
              hold_nx = hold + 1'b1;
            end
            // Period wrap: the next period runs on freshly sampled config.
            if (m_axis_tlast) begin
              mode_nx   = mode;
              hold_l_nx = hold_cycles;
              attn_nx   = attn;
            end
          end
        end else if (state == RUN && !enable) begin
          state_nx = DRAIN;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (load) begin
      tvalid_nx = 1'b1;
      tkeep_nx  = '1;
      tdata_nx  = gen_sample(mode_nx, attn_nx, phase_nx);
      tlast_nx  = (phase_nx == LAST_PH) && (hold_nx == hold_l_nx);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      phase         <= '0;
      hold          <= '0;
      mode_l        <= '0;
      hold_l        <= '0;
      attn_l        <= '0;
      period_cnt    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state         <= state_nx;
      phase         <= phase_nx;
      hold          <= hold_nx;
      mode_l        <= mode_nx;
      hold_l        <= hold_l_nx;
      attn_l        <= attn_nx;
      period_cnt    <= pc_nx;
      m_axis_tvalid <= tvalid_nx;
      m_axis_tdata  <= tdata_nx;
      m_axis_tkeep  <= tkeep_nx;
      m_axis_tlast  <= tlast_nx;
    end
  end

endmodule

// File: doc/axis_tone_gen.md
Name: axis_tone_gen

Overview:
Parametrised AXI4-Stream master that synthesises periodic test waveforms (sine, square, ramp, impulse) for driving FIR and DSP blocks in simulation and on hardware. Generalises the fixed 8-point, fixed-hold sinusoid stimulus with configurable data width, points per period, per-point hold, attenuation and full tready backpressure. Output is registered, carries tlast at the end of each period and feeds s_axis_* of downstream filters directly.

Parameters:
DATA_W, 16, sample width in bits; multiple of 8, range 8..32
PTS_LOG2, 3, log2 of points per period (N_PTS = 2**PTS_LOG2); range 3..10
HOLD_W, 8, width of hold_cycles port

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run request; level-sensitive
mode  in  2  0 = sine, 1 = square, 2 = ramp, 3 = impulse
hold_cycles  in  HOLD_W  each point is emitted hold_cycles+1 accepted beats
attn  in  4  arithmetic right shift applied to the sample (0..15)
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  DATA_W  signed sample, two's complement
m_axis_tkeep  out  DATA_W/8  all ones whenever tvalid = 1
m_axis_tlast  out  1  high on the last beat of a period
period_cnt  out  16  completed periods since leaving IDLE; wraps at 0xFFFF -> 0

Behaviour:
- Reset (async, active-high): state = IDLE; tvalid = 0, tdata = 0, tkeep = 0, tlast = 0, period_cnt = 0; phase index and hold counter = 0.
- Beat acceptance: tvalid & tready on a rising clk edge.
- While tvalid = 1 and tready = 0: tdata, tkeep and tlast held stable, counters frozen. tvalid is never withdrawn before acceptance.
- FSM states:
  - IDLE: tvalid = 0. On enable = 1, latch mode, hold_cycles and attn; set phase = 0, hold = 0; go to RUN. tvalid rises on the next edge, one cycle after enable is sampled.
  - RUN: on each acceptance, increment hold.
    - If hold == latched hold_cycles: hold <= 0 and phase <= phase + 1 (wraps at N_PTS).
    - Next beat's tdata is presented on the same edge, giving zero-bubble streaming under continuous tready.
  - DRAIN: entered from RUN when enable = 0. The current beat stays valid until accepted, then tvalid = 0, phase and hold are cleared, and the FSM returns to IDLE.
  - An acceptance and enable = 0 on the same edge go directly to IDLE with tvalid = 0.
- Config latching: config is sampled at IDLE->RUN and at every period wrap. Changes mid-period are ignored until the next period.
- tlast: high on the beat where phase = N_PTS-1 and hold = latched hold_cycles. Acceptance of that beat increments period_cnt.
- Waveforms: idx = phase; s = idx[PTS_LOG2-1 -: 3] is the 8-phase sine index. MAX = 2^(DATA_W-1) - 1, MIN = -2^(DATA_W-1).
  - Sine: 16-bit table 0x0000, 0x5A7E, 0x7FFF, 0x5A7E, 0x0000, 0xA582, 0x8000, 0xA582. For DATA_W > 16, left-justify (shift left by DATA_W-16). For DATA_W < 16, take the top DATA_W bits.
  - Square: MAX for idx < N_PTS/2, MIN otherwise.
  - Ramp: MIN + idx * 2^(DATA_W-PTS_LOG2), i.e. msb-inverted idx left-justified.
  - Impulse: MAX at idx = 0, 0 elsewhere.
- Attenuation: tdata = arithmetic right shift of the raw sample by latched attn; sign preserved.
- Reset mid-operation: immediate return to reset values regardless of handshake state.

Test Plan:
1. DATA_W = 16, PTS_LOG2 = 3, hold = 4, sine, attn = 0, tready = 1 -> beats 0x0000 x5, 0x5A7E x5, 0x7FFF x5, 0x5A7E x5, 0x0000 x5, 0xA582 x5, 0x8000 x5, 0xA582 x5; tlast only on beat 40; period_cnt = 1 after beat 40; tkeep = 0x3.
2. Ramp, hold = 0 -> 0x8000, 0xA000, 0xC000, 0xE000, 0x0000, 0x2000, 0x4000, 0x6000, then repeat; tlast on 0x6000.
3. Sine, attn = 1 -> 0x2D3F for 0x5A7E, 0x3FFF for 0x7FFF, 0xD2C1 for 0xA582, 0xC000 for 0x8000.
4. Backpressure: tready low for 10 cycles mid-point -> tdata/tlast stable, no beat skipped or duplicated; sequence identical to scenario 1 once stalls are removed.
5. Enable dropped during a tready stall -> pending beat stays valid until accepted, then tvalid = 0. Re-enable -> restarts at 0x0000 with phase 0. Change mode to square mid-period -> takes effect only after tlast.
6. Reset pulse while tvalid = 1, tready = 0 -> tvalid, tdata, tlast and period_cnt are 0 immediately. After release with enable = 1 -> first beat is the phase-0 value.
